// File: rtl/word_panel_pkg.sv
// rtl/word_panel_pkg.sv - shared types and constants for the word panel controller
package word_panel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        SEND
    } state_t;

    localparam int NUM_CHARS = 8;
    localparam int CHAR_W    = 9;
    localparam int POS_W     = 3;
    localparam int WORD_W    = 2;

    localparam logic [WORD_W-1:0] WORD_KEVIN    = 2'd0;
    localparam logic [WORD_W-1:0] WORD_HI       = 2'd1;
    localparam logic [WORD_W-1:0] WORD_IT_WORKS = 2'd2;

    function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] w,
                                                    input int num_words);
        return (int'(w) >= num_words - 1) ? WORD_KEVIN : w + WORD_W'(1);
    endfunction

endpackage

// File: rtl/word_panel_btn_debounce.sv
// rtl/word_panel_btn_debounce.sv - button synchroniser, debounce counter and press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_0;
    logic             sync_1;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    // Any cycle where the synchronised input agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_0  <= 1'b0;
            sync_1  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_0  <= btn;
            sync_1  <= sync_0;
            level_q <= level;
            if (sync_1 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/word_panel_ctrl.sv
// rtl/word_panel_ctrl.sv - word advance sequencing and 8-character display streaming
module word_panel_ctrl
    import word_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int AUTO_CYCLES     = 0,
    parameter int NUM_WORDS       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              BTN,
    input  logic              auto_en,
    output logic [WORD_W-1:0] word_sel,
    output logic              advance,
    input  logic [CHAR_W-1:0] char_0,
    input  logic [CHAR_W-1:0] char_1,
    input  logic [CHAR_W-1:0] char_2,
    input  logic [CHAR_W-1:0] char_3,
    input  logic [CHAR_W-1:0] char_4,
    input  logic [CHAR_W-1:0] char_5,
    input  logic [CHAR_W-1:0] char_6,
    input  logic [CHAR_W-1:0] char_7,
    output logic [CHAR_W-1:0] disp_char,
    output logic [POS_W-1:0]  disp_pos,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic              busy
);
    localparam int AUTO_W  = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
    localparam bit AUTO_ON = (AUTO_CYCLES != 0);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);
    localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(NUM_CHARS - 1);

    state_t            state;
    state_t            state_n;
    logic [WORD_W-1:0] word_n;
    logic [POS_W-1:0]  pos_n;
    logic              pending;
    logic              pending_n;
    logic [AUTO_W-1:0] auto_cnt;
    logic              btn_req;
    logic              auto_req;
    logic              req;
    logic [CHAR_W-1:0] chars  [NUM_CHARS];
    logic [CHAR_W-1:0] shadow [NUM_CHARS];

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (BTN),
        .rise (btn_req)
    );

    assign chars    = '{char_0, char_1, char_2, char_3, char_4, char_5, char_6, char_7};
    assign auto_req = AUTO_ON && auto_en && (auto_cnt == AUTO_LAST);
    assign req      = btn_req | auto_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (!AUTO_ON || !auto_en || advance || auto_req) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + AUTO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            word_sel <= WORD_KEVIN;
            disp_pos <= '0;
            pending  <= 1'b1;
            for (int i = 0; i < NUM_CHARS; i++) shadow[i] <= '0;
        end else begin
            state    <= state_n;
            word_sel <= word_n;
            disp_pos <= pos_n;
            pending  <= pending_n;
            if (state == SNAP) begin
                for (int i = 0; i < NUM_CHARS; i++) shadow[i] <= chars[i];
            end
        end
    end

    // A pending flag seen in IDLE only comes from reset: refresh the current word without stepping.
    always_comb begin
        state_n   = state;
        word_n    = word_sel;
        pos_n     = disp_pos;
        pending_n = pending;
        advance   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) begin
                    pending_n = 1'b0;
                    state_n   = SNAP;
                end else if (req) begin
                    advance = 1'b1;
                    word_n  = next_word(word_sel, NUM_WORDS);
                    state_n = SNAP;
                end
            end
            SNAP: begin
                pos_n     = '0;
                pending_n = pending | req;
                state_n   = SEND;
            end
            SEND: begin
                pending_n = pending | req;
                if (disp_ready) begin
                    if (disp_pos == LAST_POS) begin
                        if (pending || req) begin
                            advance   = 1'b1;
                            word_n    = next_word(word_sel, NUM_WORDS);
                            pending_n = 1'b0;
                            state_n   = SNAP;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        pos_n = disp_pos + POS_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign disp_valid = (state == SEND);
    assign busy       = (state != IDLE);
    assign disp_char  = (state == SEND) ? shadow[disp_pos] : '0;

endmodule

// File: tb/tb_word_panel_ctrl.sv
// tb/tb_word_panel_ctrl.sv - randomized self-checking bench for word_panel_ctrl
module tb_word_panel_ctrl;
    localparam int DEB  = 4;
    localparam int AUTO = 20;
    localparam int NW   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       BTN = 1'b0;
    logic       auto_en = 1'b0;
    logic       disp_ready = 1'b0;
    logic [1:0] word_sel;
    logic       advance;
    logic [8:0] disp_char;
    logic [2:0] disp_pos;
    logic       disp_valid;
    logic       busy;

    logic [8:0] tbl [NW][8];
    logic [8:0] ch [8];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_word = 0;
    int adv_cyc[$];
    int beat_pos[$];
    logic [8:0] beat_char[$];
    logic [8:0] exp_q[$];

    word_panel_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .AUTO_CYCLES    (AUTO),
        .NUM_WORDS      (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .BTN       (BTN),
        .auto_en   (auto_en),
        .word_sel  (word_sel),
        .advance   (advance),
        .char_0    (ch[0]),
        .char_1    (ch[1]),
        .char_2    (ch[2]),
        .char_3    (ch[3]),
        .char_4    (ch[4]),
        .char_5    (ch[5]),
        .char_6    (ch[6]),
        .char_7    (ch[7]),
        .disp_char (disp_char),
        .disp_pos  (disp_pos),
        .disp_valid(disp_valid),
        .disp_ready(disp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 8; k++) ch[k] = (int'(word_sel) < NW) ? tbl[word_sel][k] : 9'h000;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (advance) adv_cyc.push_back(cyc);
            if (disp_valid && disp_ready) begin
                beat_pos.push_back(int'(disp_pos));
                beat_char.push_back(disp_char);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        adv_cyc.delete();
        beat_pos.delete();
        beat_char.delete();
        exp_q.delete();
    endtask

    task automatic push_exp(input int w);
        for (int k = 0; k < 8; k++) exp_q.push_back(tbl[w][k]);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle busy stuck got %b want 0", busy);
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        disp_ready = 1'b1;
        step(3);
        checks++;
        if ({word_sel, advance, disp_valid, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got sel %0d adv %b valid %b busy %b want 0", word_sel, advance, disp_valid, busy);
        end
        checks++;
        if (disp_pos !== 3'd0 || disp_char !== 9'd0) begin
            errors++;
            $display("FAIL reset_disp got pos %0d char %h want 0 0", disp_pos, disp_char);
        end
        clear_logs();
        model_word = 0;
        push_exp(0);
        rst_n = 1'b1;
        #1;
        checks++;
        if (advance !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle got adv %b busy %b want 0 0", advance, busy);
        end
        step();
        checks++;
        if (busy !== 1'b1 || disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_snap got busy %b valid %b want 1 0", busy, disp_valid);
        end
        step();
        checks++;
        if (disp_valid !== 1'b1 || disp_pos !== 3'd0 || disp_char !== exp_q[0]) begin
            errors++;
            $display("FAIL reset_first_beat got valid %b pos %0d char %h want 1 0 %h", disp_valid, disp_pos, disp_char, exp_q[0]);
        end
        wait_idle(n);
        checks++;
        if (n !== 8 || adv_cyc.size() !== 0 || word_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_refresh got cycles %0d advs %0d sel %0d want 8 0 0", n, adv_cyc.size(), word_sel);
        end
        checks++;
        if (beat_pos.size() !== 8) begin
            errors++;
            $display("FAIL reset_beat_count got %0d want 8", beat_pos.size());
        end
        for (int k = 0; k < beat_pos.size() && k < exp_q.size(); k++) begin
            checks++;
            if (beat_pos[k] !== k % 8 || beat_char[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL reset_beat%0d got pos %0d char %h want pos %0d char %h", k, beat_pos[k], beat_char[k], k % 8, exp_q[k]);
            end
        end
    endtask

    task automatic test_press();
        int lat = 0;
        int n;
        clear_logs();
        model_word = (model_word + 1) % NW;
        push_exp(model_word);
        BTN = 1'b1;
        do begin
            step();
            lat++;
        end while (advance !== 1'b1 && lat < 50);
        // Press to advance: two synchroniser cycles plus DEB stable cycles.
        checks++;
        if (lat !== DEB + 2) begin
            errors++;
            $display("FAIL press_latency got %0d want %0d", lat, DEB + 2);
        end
        step(10 - lat);
        BTN = 1'b0;
        wait_idle(n);
        step(DEB + 4);
        checks++;
        if (adv_cyc.size() !== 1 || int'(word_sel) !== model_word) begin
            errors++;
            $display("FAIL press_advance got advs %0d sel %0d want 1 %0d", adv_cyc.size(), word_sel, model_word);
        end
        checks++;
        if (beat_pos.size() !== 8) begin
            errors++;
            $display("FAIL press_beat_count got %0d want 8", beat_pos.size());
        end
        for (int k = 0; k < beat_pos.size() && k < exp_q.size(); k++) begin
            checks++;
            if (beat_pos[k] !== k % 8 || beat_char[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL press_beat%0d got pos %0d char %h want pos %0d char %h", k, beat_pos[k], beat_char[k], k % 8, exp_q[k]);
            end
        end
        clear_logs();
        repeat (4) begin
            BTN = 1'b1;
            step(3);
            BTN = 1'b0;
            step(3);
        end
        step(DEB + 6);
        checks++;
        if (adv_cyc.size() !== 0 || int'(word_sel) !== model_word) begin
            errors++;
            $display("FAIL bounce_ignored got advs %0d sel %0d want 0 %0d", adv_cyc.size(), word_sel, model_word);
        end
    endtask

    task automatic test_wrap();
        int n;
        for (int p = 0; p < 3; p++) begin
            clear_logs();
            model_word = (model_word + 1) % NW;
            push_exp(model_word);
            BTN = 1'b1;
            step($urandom_range(7, 12));
            BTN = 1'b0;
            wait_idle(n);
            step(DEB + 4);
            checks++;
            if (adv_cyc.size() !== 1 || int'(word_sel) !== model_word) begin
                errors++;
                $display("FAIL wrap_press%0d got advs %0d sel %0d want 1 %0d", p, adv_cyc.size(), word_sel, model_word);
            end
            for (int k = 0; k < beat_pos.size() && k < exp_q.size(); k++) begin
                checks++;
                if (beat_pos[k] !== k % 8 || beat_char[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL wrap%0d_beat%0d got pos %0d char %h want pos %0d char %h", p, k, beat_pos[k], beat_char[k], k % 8, exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic       pv, pr, started, scrambled;
        int         ppos;
        logic [8:0] pc;
        clear_logs();
        model_word = (model_word + 1) % NW;
        push_exp(model_word);
        started = 1'b0;
        scrambled = 1'b0;
        BTN = 1'b1;
        for (int i = 0; i < 150; i++) begin
            disp_ready = (i % 2 == 0);
            pv = disp_valid;
            pr = disp_ready;
            ppos = int'(disp_pos);
            pc = disp_char;
            step();
            if (i == 10) BTN = 1'b0;
            if (pv && !pr) begin
                checks++;
                if (int'(disp_pos) !== ppos || disp_char !== pc) begin
                    errors++;
                    $display("FAIL stall_hold got pos %0d char %h want pos %0d char %h", disp_pos, disp_char, ppos, pc);
                end
            end
            // Datapath changes after the snapshot must not reach the stream.
            if (disp_valid && !scrambled) begin
                for (int k = 0; k < 8; k++) tbl[model_word][k] = 9'($urandom);
                scrambled = 1'b1;
            end
            if (started && !busy) break;
            if (busy) started = 1'b1;
        end
        disp_ready = 1'b1;
        step(DEB + 4);
        checks++;
        if (beat_pos.size() !== 8 || adv_cyc.size() !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_count got beats %0d advs %0d busy %b want 8 1 0", beat_pos.size(), adv_cyc.size(), busy);
        end
        for (int k = 0; k < beat_pos.size() && k < exp_q.size(); k++) begin
            checks++;
            if (beat_pos[k] !== k % 8 || beat_char[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL stall_beat%0d got pos %0d char %h want pos %0d char %h", k, beat_pos[k], beat_char[k], k % 8, exp_q[k]);
            end
        end
    endtask

    task automatic test_pending();
        int i;
        clear_logs();
        disp_ready = 1'b0;
        model_word = (model_word + 1) % NW;
        push_exp(model_word);
        model_word = (model_word + 1) % NW;
        push_exp(model_word);
        repeat (3) begin
            BTN = 1'b1;
            step(8);
            BTN = 1'b0;
            step(DEB + 4);
        end
        disp_ready = 1'b1;
        for (i = 0; i < 80; i++) begin
            step();
            if (!busy) break;
        end
        checks++;
        if (beat_pos.size() !== 16 || adv_cyc.size() !== 2 || int'(word_sel) !== model_word) begin
            errors++;
            $display("FAIL pending_merge got beats %0d advs %0d sel %0d want 16 2 %0d", beat_pos.size(), adv_cyc.size(), word_sel, model_word);
        end
        for (int k = 0; k < beat_pos.size() && k < exp_q.size(); k++) begin
            checks++;
            if (beat_pos[k] !== k % 8 || beat_char[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL pending_beat%0d got pos %0d char %h want pos %0d char %h", k, beat_pos[k], beat_char[k], k % 8, exp_q[k]);
            end
        end
    endtask

    task automatic test_auto();
        int l;
        int n;
        clear_logs();
        disp_ready = 1'b1;
        for (int w = 1; w <= 4; w++) push_exp((model_word + w) % NW);
        auto_en = 1'b1;
        for (int i = 0; i < 120 && adv_cyc.size() < 4; i++) step();
        checks++;
        if (adv_cyc.size() !== 4) begin
            errors++;
            $display("FAIL auto_count got %0d want 4", adv_cyc.size());
            auto_en = 1'b0;
            return;
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (adv_cyc[i] - adv_cyc[i-1] !== AUTO) begin
                errors++;
                $display("FAIL auto_period%0d got %0d want %0d", i, adv_cyc[i] - adv_cyc[i-1], AUTO);
            end
        end
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (k >= beat_pos.size() || beat_pos[k] !== k % 8 || beat_char[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL auto_beat%0d got %0d beats want char %h at pos %0d", k, beat_pos.size(), exp_q[k], k % 8);
            end
        end
        model_word = (model_word + 4) % NW;
        l = adv_cyc[3];
        while (cyc < l + AUTO - (DEB + 2)) step();
        BTN = 1'b1;
        step(10);
        auto_en = 1'b0;
        BTN = 1'b0;
        wait_idle(n);
        step(DEB + 4);
        model_word = (model_word + 1) % NW;
        checks++;
        if (adv_cyc.size() !== 5 || int'(word_sel) !== model_word) begin
            errors++;
            $display("FAIL auto_btn_merge got advs %0d sel %0d want 5 %0d", adv_cyc.size(), word_sel, model_word);
        end else begin
            checks++;
            if (adv_cyc[4] !== l + AUTO) begin
                errors++;
                $display("FAIL auto_btn_cycle got %0d want %0d", adv_cyc[4], l + AUTO);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        disp_ready = 1'b1;
        BTN = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 8) BTN = 1'b0;
            if (disp_valid && disp_pos == 3'd3) begin
                disp_ready = 1'b0;
                break;
            end
        end
        BTN = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (disp_valid !== 1'b0 || busy !== 1'b0 || word_sel !== 2'd0 || disp_pos !== 3'd0 || advance !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async got valid %b busy %b sel %0d pos %0d adv %b want 0 0 0 0 0",
                     disp_valid, busy, word_sel, disp_pos, advance);
        end
        step(2);
        clear_logs();
        model_word = 0;
        push_exp(0);
        disp_ready = 1'b1;
        rst_n = 1'b1;
        step();
        wait_idle(n);
        checks++;
        if (beat_pos.size() !== 8 || adv_cyc.size() !== 0 || word_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_refresh got beats %0d advs %0d sel %0d want 8 0 0", beat_pos.size(), adv_cyc.size(), word_sel);
        end
        for (int k = 0; k < beat_pos.size() && k < exp_q.size(); k++) begin
            checks++;
            if (beat_pos[k] !== k % 8 || beat_char[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL reset_mid_beat%0d got pos %0d char %h want pos %0d char %h", k, beat_pos[k], beat_char[k], k % 8, exp_q[k]);
            end
        end
    endtask

    initial begin
        for (int w = 0; w < NW; w++)
            for (int k = 0; k < 8; k++) tbl[w][k] = 9'($urandom);
        test_reset();
        test_press();
        test_wrap();
        test_stall();
        test_pending();
        test_auto();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
